shift_pipe: RTL

Parametrised, pipelined barrel shifter with valid/ready handshakes on both sides. It is the multi-cycle successor to the single-cycle ALU shifter. It supports logical and arithmetic shifts, and optionally rotates, on XLEN-bit operands, split over STAGES register stages. It sits between the execute-stage operand muxes and the writeback mux, and is used when a long shift path must be cut for timing.

---
 rtl/shift_pkg.sv | 29 ++
 rtl/shift_level.sv | 45 ++++
 rtl/shift_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// Module  : shift_pkg
// Brief   : Op codes, op type and stage/level partitioning for shift_pipe.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    typedef logic [2:0] shift_op_t;

    localparam shift_op_t SH_SRL = 3'b000;
    localparam shift_op_t SH_SLL = 3'b001;
    localparam shift_op_t SH_SRA = 3'b010;
    localparam shift_op_t SH_ROR = 3'b011;
    localparam shift_op_t SH_ROL = 3'b100;

    // Levels are spread over the stages in order, as evenly as floor() allows.
    function automatic int stage_first_level(input int k, input int levels, input int stages);
        return (k * levels) / stages;
    endfunction

    function automatic int stage_last_level(input int k, input int levels, input int stages);
        return (((k + 1) * levels) / stages) - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_level.sv
// ============================================================================
// Module  : shift_level
// Brief   : One combinational level of the barrel shifter, moving by DIST bits.
//           Rotates are built only when SHIFT_PIPE_ROTATE_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module shift_level
    import shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int DIST = 1
) (
    input  logic [XLEN-1:0] data,
    input  logic            enable,
    input  shift_op_t       op,
    input  logic            sign,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] w_fill;

    // SRA takes the sign latched at entry rather than this level's MSB.
    assign w_fill = sign ? ~({XLEN{1'b1}} >> DIST) : '0;

    always_comb begin
        result = data;
        if (enable) begin
            case (op)
                SH_SRL:  result = data >> DIST;
                SH_SLL:  result = data << DIST;
                SH_SRA:  result = (data >> DIST) | w_fill;
`ifdef SHIFT_PIPE_ROTATE_EN
                SH_ROR:  result = (data >> DIST) | (data << (XLEN - DIST));
                SH_ROL:  result = (data << DIST) | (data >> (XLEN - DIST));
`endif
                default: result = data;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_pipe.sv
// ============================================================================
// Module  : shift_pipe
// Brief   : Pipelined barrel shifter, global-stall valid/ready pipeline over
//           STAGES register stages. Rotates enabled by SHIFT_PIPE_ROTATE_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module shift_pipe
    import shift_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int STAGES = 2,
    localparam int LEVELS = $clog2(XLEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_a,
    input  logic [LEVELS-1:0] in_shamt,
    input  shift_op_t         in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_r
);

    logic              r_valid [STAGES];
    logic [XLEN-1:0]   r_data  [STAGES];
    logic [LEVELS-1:0] r_shamt [STAGES];
    shift_op_t         r_op    [STAGES];
    logic              r_sign  [STAGES];

    logic              w_sin_valid [STAGES];
    logic [XLEN-1:0]   w_sin_data  [STAGES];
    logic [LEVELS-1:0] w_sin_shamt [STAGES];
    shift_op_t         w_sin_op    [STAGES];
    logic              w_sin_sign  [STAGES];
    logic [XLEN-1:0]   w_sout_data [STAGES];

    logic [XLEN-1:0]   w_lvl_in  [LEVELS];
    logic [XLEN-1:0]   w_lvl_out [LEVELS];

    logic              w_advance;
    logic [STAGES-1:0] w_unused_bits;

    assign w_advance = out_ready | ~r_valid[STAGES-1];
    assign in_ready  = w_advance & ~flush;
    assign out_valid = r_valid[STAGES-1];
    assign out_r     = r_data[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_lo = stage_first_level(k, LEVELS, STAGES);
        localparam int c_hi = stage_last_level(k, LEVELS, STAGES);

        if (k == 0) begin : g_head
            assign w_sin_valid[k] = in_valid & in_ready;
            assign w_sin_data[k]  = in_a;
            assign w_sin_shamt[k] = in_shamt;
            assign w_sin_op[k]    = in_op;
            assign w_sin_sign[k]  = in_a[XLEN-1];
        end else begin : g_body
            assign w_sin_valid[k] = r_valid[k-1];
            assign w_sin_data[k]  = r_data[k-1];
            assign w_sin_shamt[k] = r_shamt[k-1];
            assign w_sin_op[k]    = r_op[k-1];
            assign w_sin_sign[k]  = r_sign[k-1];
        end

        for (genvar i = c_lo; i <= c_hi; i++) begin : g_level
            if (i == c_lo) begin : g_first
                assign w_lvl_in[i] = w_sin_data[k];
            end else begin : g_chain
                assign w_lvl_in[i] = w_lvl_out[i-1];
            end

            shift_level #(
                .XLEN (XLEN),
                .DIST (1 << i)
            ) u_level (
                .data   (w_lvl_in[i]),
                .enable (w_sin_shamt[k][i]),
                .op     (w_sin_op[k]),
                .sign   (w_sin_sign[k]),
                .result (w_lvl_out[i])
            );
        end

        if (c_hi >= c_lo) begin : g_out
            assign w_sout_data[k] = w_lvl_out[c_hi];
        end else begin : g_pass
            assign w_sout_data[k] = w_sin_data[k];
        end

        // Control travelling past the levels that consume it is left for synthesis to trim.
        assign w_unused_bits[k] = ^{r_shamt[k], r_op[k], r_sign[k]};
    end

    // Data only loads behind a valid beat, so out_r holds 0 from reset until the first result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_data[k]  <= '0;
                r_shamt[k] <= '0;
                r_op[k]    <= SH_SRL;
                r_sign[k]  <= 1'b0;
            end
        end else if (flush) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_sin_valid[k];
                if (w_sin_valid[k]) begin
                    r_data[k]  <= w_sout_data[k];
                    r_shamt[k] <= w_sin_shamt[k];
                    r_op[k]    <= w_sin_op[k];
                    r_sign[k]  <= w_sin_sign[k];
                end
            end
        end
    end

endmodule

`default_nettype wire
